// File: rtl/aibnd_red_shift_ctrl.sv
// Per-column redundancy shift controller: turns a failing-lane request into a thermometer
// shift_en vector, sequenced gate -> update -> settle -> ungate. Optional: AIBND_RED_SHIFT_LOCK_EN.
module aibnd_red_shift_ctrl #(
   parameter int unsigned NUM_LANES = 24,
   parameter int unsigned LW        = 5,
   parameter int unsigned GATE_CYC  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [LW-1:0]        req_lane,
   input  logic                 req_repair,
   output logic [NUM_LANES-1:0] shift_en,
   output logic                 clk_gate_n,
   output logic                 done,
   output logic                 err,
   output logic                 busy
);

   localparam int unsigned CW = 4;
   // UPDATE is itself a gated cycle, so GATE covers the remaining GATE_CYC-1 pre-change cycles
   localparam logic [CW-1:0] GATE_LAST   = CW'((GATE_CYC >= 2) ? (GATE_CYC - 2) : 0);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(GATE_CYC - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GATE   = 2'd1,
      UPDATE = 2'd2,
      SETTLE = 2'd3
   } state_t;

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [LW-1:0]          lane_q;
   logic                   repair_q;
   logic [NUM_LANES-1:0]   target;
   logic                   locked;
   logic                   bad_lane;

   assign bad_lane = req_repair && (32'(req_lane) >= NUM_LANES);

   // Thermometer: every lane at or above the failing one takes its neighbour's input
   always_comb begin
      target = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         target[i] = repair_q && (32'(i) >= 32'(lane_q));
      end
   end

`ifdef AIBND_RED_SHIFT_LOCK_EN
   logic lock_q;

   // Sticky after the first completed repair; only reset releases it
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q <= 1'b0;
      end else if (state == SETTLE && cnt == SETTLE_LAST && repair_q) begin
         lock_q <= 1'b1;
      end
   end

   assign locked = lock_q;
`else
   assign locked = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         lane_q     <= '0;
         repair_q   <= 1'b0;
         shift_en   <= '0;
         clk_gate_n <= 1'b1;
         req_ready  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  lane_q   <= req_lane;
                  repair_q <= req_repair;
                  cnt      <= '0;
                  if (locked || bad_lane) begin
                     err <= 1'b1;
                  end else begin
                     clk_gate_n <= 1'b0;
                     req_ready  <= 1'b0;
                     busy       <= 1'b1;
                     state      <= (GATE_CYC == 1) ? UPDATE : GATE;
                  end
               end
            end
            GATE: begin
               if (cnt == GATE_LAST) begin
                  cnt   <= '0;
                  state <= UPDATE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            UPDATE: begin
               shift_en <= target;
               cnt      <= '0;
               state    <= SETTLE;
            end
            SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  cnt        <= '0;
                  clk_gate_n <= 1'b1;
                  req_ready  <= 1'b1;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aibnd_red_shift_ctrl.sv
// Bench for aibnd_red_shift_ctrl at default parameters; responses are matched against a
// scoreboard queue filled as requests are issued. AIBND_RED_SHIFT_LOCK_EN selects the lock scenario.
module tb_aibnd_red_shift_ctrl;

   localparam int unsigned NL = 24;
   localparam int unsigned G  = 4;

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [4:0]    req_lane;
   logic          req_repair;
   logic [NL-1:0] shift_en;
   logic          clk_gate_n;
   logic          done;
   logic          err;
   logic          busy;

   aibnd_red_shift_ctrl #(.NUM_LANES(NL), .LW(5), .GATE_CYC(G)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_lane   (req_lane),
      .req_repair (req_repair),
      .shift_en   (shift_en),
      .clk_gate_n (clk_gate_n),
      .done       (done),
      .err        (err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          is_err;
      logic [NL-1:0] shift;
   } exp_t;

   typedef struct {
      logic [4:0]    lane;
      logic          rep;
      logic          is_err;
      logic [NL-1:0] shift;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[8];
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Every done/err pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && (done || err)) begin
         check("done_err_exclusive", 64'(done && err), 64'(0));
         if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_resp: done=%0b err=%0b with nothing outstanding at %0t", done, err, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("resp_kind_err", 64'(err), 64'(e.is_err));
            check("resp_shift_en", 64'(shift_en), 64'(e.shift));
         end
      end
   end

   task automatic send(input logic [4:0] lane, input logic rep, input logic push,
                       input logic is_err, input logic [NL-1:0] exp_shift);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         total_cnt++;
         $display("FAIL send_timeout: req_ready=%0b expected 1", req_ready);
      end
      if (push) sb.push_back('{is_err, exp_shift});
      req_valid  = 1'b1;
      req_lane   = lane;
      req_repair = rep;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_lane   = 5'($urandom_range(0, 31));
      req_repair = 1'($urandom_range(0, 1));
   endtask

   // Leaves the caller at the negedge where done or err is high
   task automatic wait_resp();
      int n;
      n = 0;
      @(negedge clk);
      while (!(done || err) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!(done || err)) begin
         total_cnt++;
         $display("FAIL resp_timeout: done=%0b err=%0b expected a pulse", done, err);
      end
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      logic [NL-1:0] pre_shift;
      int            done_seen;

      vecs[0] = '{5'd23, 1'b1, 1'b0, 24'h800000};
      vecs[1] = '{5'd24, 1'b1, 1'b1, 24'h800000};
      vecs[2] = '{5'd31, 1'b0, 1'b0, 24'h000000};
      vecs[3] = '{5'd31, 1'b1, 1'b1, 24'h000000};
      vecs[4] = '{5'd12, 1'b1, 1'b0, 24'hFFF000};
      vecs[5] = '{5'd12, 1'b1, 1'b0, 24'hFFF000};
      vecs[6] = '{5'd1,  1'b1, 1'b0, 24'hFFFFFE};
      vecs[7] = '{5'd0,  1'b0, 1'b0, 24'h000000};

      rst        = 1'b1;
      req_valid  = 1'b0;
      req_lane   = '0;
      req_repair = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_shift_en",   64'(shift_en),   64'(0));
      check("rst_clk_gate_n", 64'(clk_gate_n), 64'(1));
      check("rst_req_ready",  64'(req_ready),  64'(1));
      check("rst_busy",       64'(busy),       64'(0));
      check("rst_done",       64'(done),       64'(0));
      check("rst_err",        64'(err),        64'(0));
      rst = 1'b0;

      // Repair lane 5: cycle-by-cycle timing after the acceptance edge
      send(5'd5, 1'b1, 1'b1, 1'b0, 24'hFFFFE0);
      for (int k = 1; k <= 2 * G + 1; k++) begin
         @(negedge clk);
         check($sformatf("r5_gate_c%0d", k),  64'(clk_gate_n), 64'((k <= 2 * G) ? 0 : 1));
         check($sformatf("r5_shift_c%0d", k), 64'(shift_en),   64'((k <= G) ? 24'h0 : 24'hFFFFE0));
         check($sformatf("r5_done_c%0d", k),  64'(done),       64'((k == 2 * G + 1) ? 1 : 0));
         check($sformatf("r5_ready_c%0d", k), 64'(req_ready),  64'((k == 2 * G + 1) ? 1 : 0));
      end

`ifdef AIBND_RED_SHIFT_LOCK_EN
      do_reset(1);
      send(5'd3, 1'b1, 1'b1, 1'b0, 24'hFFFFF8);
      wait_resp();
      send(5'd7, 1'b1, 1'b1, 1'b1, 24'hFFFFF8);
      wait_resp();
      check("lock_gate_on_err", 64'(clk_gate_n), 64'(1));
      send(5'd0, 1'b0, 1'b1, 1'b1, 24'hFFFFF8);
      wait_resp();
      do_reset(1);
      send(5'd7, 1'b1, 1'b1, 1'b0, 24'hFFFF80);
      wait_resp();
`else
      // Table: each request runs to its done/err pulse
      for (int v = 0; v < 8; v++) begin
         send(vecs[v].lane, vecs[v].rep, 1'b1, vecs[v].is_err, vecs[v].shift);
         wait_resp();
         check($sformatf("vec%0d_err", v),   64'(err),        64'(vecs[v].is_err));
         check($sformatf("vec%0d_gate", v),  64'(clk_gate_n), 64'(1));
         check($sformatf("vec%0d_busy", v),  64'(busy),       64'(0));
         check($sformatf("vec%0d_shift", v), 64'(shift_en),   64'(vecs[v].shift));
      end

      // Back-to-back: clear presented in the done cycle of a lane-0 repair
      send(5'd0, 1'b1, 1'b1, 1'b0, 24'hFFFFFF);
      wait_resp();
      check("b2b_ready_on_done", 64'(req_ready), 64'(1));
      sb.push_back('{1'b0, 24'h000000});
      req_valid  = 1'b1;
      req_lane   = 5'd9;
      req_repair = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      for (int k = 1; k <= G + 1; k++) begin
         @(negedge clk);
         check($sformatf("b2b_busy_c%0d", k),  64'(busy),     64'(1));
         check($sformatf("b2b_shift_c%0d", k), 64'(shift_en), 64'((k <= G) ? 24'hFFFFFF : 24'h0));
      end
      wait_resp();

      // Reset during SETTLE aborts with no done
      send(5'd10, 1'b1, 1'b0, 1'b0, 24'h0);
      repeat (G + 1) @(negedge clk);
      check("mid_shift_before_rst", 64'(shift_en), 64'(24'hFFFC00));
      @(negedge clk);
      pre_shift = shift_en;
      check("mid_in_settle", 64'(clk_gate_n), 64'(0));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_shift_en",   64'(shift_en),   64'(0));
      check("mid_rst_clk_gate_n", 64'(clk_gate_n), 64'(1));
      check("mid_rst_req_ready",  64'(req_ready),  64'(1));
      check("mid_rst_busy",       64'(busy),       64'(0));
      done_seen = 0;
      for (int k = 0; k < 3 * G; k++) begin
         if (done) done_seen++;
         @(negedge clk);
      end
      check("mid_rst_no_done", 64'(done_seen), 64'(0));
      check("mid_rst_pre_shift_was_set", 64'(pre_shift), 64'(24'hFFFC00));
`endif

      repeat (2) @(negedge clk);
      check("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
